// File: rtl/ws2812b_pkg.sv
// Shared constants and types for the WS2812B frame sender.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state encoding, default bit/latch timing at 100 MHz, pixel width,
// and a small max helper used to size the shared timing counter.
package ws2812b_pkg;

  localparam int BITS_PER_PIXEL = 24;

  // Default timing in 100 MHz clock cycles; each bit period is 125 cycles.
  localparam int DEF_T0H        = 40;
  localparam int DEF_T0L        = 85;
  localparam int DEF_T1H        = 80;
  localparam int DEF_T1L        = 45;
  localparam int DEF_RES_CYCLES = 6000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ws2812b_frame_sender_if.sv
// Pixel stream from the pattern/colour generator into the frame sender.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a pixel transfers on a clock edge where both are high.
// Signals: pixel_data {G,R,B} MSB first, pixel_valid (master), pixel_ready (slave).
interface ws2812b_frame_sender_if;
  import ws2812b_pkg::*;

  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic                      pixel_valid;
  logic                      pixel_ready;

  modport master (output pixel_data, output pixel_valid, input pixel_ready);
  modport slave  (input pixel_data, input pixel_valid, output pixel_ready);

endinterface

// File: rtl/ws2812b_bit_timer.sv
// Loadable down-counter timing the HIGH, LOW and LATCH phases.
// Latency: load value N-1 gives expired after exactly N cycles in the phase.
// Backpressure: none; holds at zero once expired, never wraps.
// Ports: clk, reset (sync, active-high), load, value (N-1), expired (count == 0).
module ws2812b_bit_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ws2812b_frame_sender.sv
// Serialises NUM_LEDS GRB pixels onto the WS2812B line, then a latch low period and frame_done.
// Latency: start -> first dout high 1 cycle after LOAD; frame = NUM_LEDS*3000 + RES_CYCLES + 1 cycles.
// Backpressure: pixel_ready only in LOAD; a missing pixel stretches the low time and pulses underflow once.
// Ports: clk, reset (sync, active-high), start, pix (pixel stream slave), dout, busy, frame_done, underflow.
module ws2812b_frame_sender
  import ws2812b_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int T0H        = DEF_T0H,
  parameter int T0L        = DEF_T0L,
  parameter int T1H        = DEF_T1H,
  parameter int T1L        = DEF_T1L,
  parameter int RES_CYCLES = DEF_RES_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  ws2812b_frame_sender_if.slave  pix,
  output logic                   dout,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underflow
);

  localparam int TW  = $clog2(max3(T1H, T0L, RES_CYCLES) + 1);
  localparam int PW  = $clog2(NUM_LEDS + 1);
  localparam int MSB = BITS_PER_PIXEL - 1;

  state_t                    state, state_next;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [4:0]                bit_cnt;
  logic [PW-1:0]             pix_cnt;
  logic                      stalled;

  logic                      tmr_load;
  logic [TW-1:0]             tmr_val;
  logic                      tmr_expired;
  logic                      cap, shift, done_next;

  function automatic logic [TW-1:0] high_load(input logic b);
    return b ? TW'(T1H - 1) : TW'(T0H - 1);
  endfunction

  // The LOAD cycle that follows a pixel's last bit counts as low time, so that
  // bit's LOW phase is shortened by one to keep the 125-cycle period exact.
  function automatic logic [TW-1:0] low_load(input logic b, input logic before_load);
    int n;
    n = b ? T1L : T0L;
    if (before_load) n = n - 1;
    return TW'(n - 1);
  endfunction

  ws2812b_bit_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_val),
    .expired (tmr_expired)
  );

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    cap        = 1'b0;
    shift      = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (pix.pixel_valid) begin
          cap        = 1'b1;
          state_next = ST_HIGH;
          tmr_load   = 1'b1;
          tmr_val    = high_load(pix.pixel_data[MSB]);
        end
      end
      ST_HIGH: begin
        if (tmr_expired) begin
          state_next = ST_LOW;
          tmr_load   = 1'b1;
          tmr_val    = low_load(shreg[MSB], (bit_cnt == 5'd0) && (pix_cnt != PW'(NUM_LEDS)));
        end
      end
      ST_LOW: begin
        if (tmr_expired) begin
          if (bit_cnt != 5'd0) begin
            shift      = 1'b1;
            state_next = ST_HIGH;
            tmr_load   = 1'b1;
            tmr_val    = high_load(shreg[MSB-1]);
          end else if (pix_cnt != PW'(NUM_LEDS)) begin
            state_next = ST_LOAD;
          end else begin
            state_next = ST_LATCH;
            tmr_load   = 1'b1;
            tmr_val    = TW'(RES_CYCLES - 1);
          end
        end
      end
      ST_LATCH: begin
        if (tmr_expired) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underflow  <= 1'b0;
      stalled    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
    end else begin
      state      <= state_next;
      dout       <= (state_next == ST_HIGH);
      busy       <= (state_next != ST_IDLE);
      frame_done <= done_next;
      // Only the first starved LOAD cycle reports; a long stall is one event.
      underflow  <= (state == ST_LOAD) && !pix.pixel_valid && !stalled;
      stalled    <= (state == ST_LOAD) && !pix.pixel_valid;
      if (state == ST_IDLE && start) pix_cnt <= '0;
      if (cap) begin
        shreg   <= pix.pixel_data;
        bit_cnt <= 5'(MSB);
        pix_cnt <= pix_cnt + PW'(1);
      end else if (shift) begin
        shreg   <= {shreg[MSB-1:0], 1'b0};
        bit_cnt <= bit_cnt - 5'd1;
      end
    end
  end

  assign pix.pixel_ready = (state == ST_LOAD);

endmodule

// File: tb/tb_ws2812b_frame_sender.sv
// Bench for ws2812b_frame_sender: a 1-LED and an 8-LED instance share stimulus;
// sel picks which one is started and observed. dout edges are timestamped in
// clock edges and compared against the hand-derived WS2812B bit timing.
module tb_ws2812b_frame_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, sel;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        start1, start8;
  logic        d1_dout, d1_busy, d1_done, d1_uf;
  logic        d8_dout, d8_busy, d8_done, d8_uf;
  logic        o_dout, o_busy, o_done, o_uf, o_ready;

  ws2812b_frame_sender_if if1();
  ws2812b_frame_sender_if if8();

  assign if1.pixel_data  = pixel_data;
  assign if1.pixel_valid = pixel_valid;
  assign if8.pixel_data  = pixel_data;
  assign if8.pixel_valid = pixel_valid;
  assign start1 = start & ~sel;
  assign start8 = start & sel;

  ws2812b_frame_sender #(.NUM_LEDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pix(if1),
    .dout(d1_dout), .busy(d1_busy), .frame_done(d1_done), .underflow(d1_uf)
  );

  ws2812b_frame_sender #(.NUM_LEDS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .pix(if8),
    .dout(d8_dout), .busy(d8_busy), .frame_done(d8_done), .underflow(d8_uf)
  );

  assign o_dout  = sel ? d8_dout : d1_dout;
  assign o_busy  = sel ? d8_busy : d1_busy;
  assign o_done  = sel ? d8_done : d1_done;
  assign o_uf    = sel ? d8_uf   : d1_uf;
  assign o_ready = sel ? if8.pixel_ready : if1.pixel_ready;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  logic [23:0] tab [8];

  int   rise_q [$];
  int   fall_q [$];
  int   done_n, uf_n, done_edge;
  logic prev_dout = 1'b0;

  always @(posedge clk) edge_n++;

  // Edge times are the index of the posedge that produced the change.
  always @(negedge clk) begin
    if (o_dout === 1'b1 && prev_dout === 1'b0) rise_q.push_back(edge_n);
    if (o_dout === 1'b0 && prev_dout === 1'b1) fall_q.push_back(edge_n);
    if (o_done === 1'b1) begin
      done_n++;
      done_edge = edge_n;
    end
    if (o_uf === 1'b1) uf_n++;
    prev_dout = o_dout;
  end

  function automatic logic exp_bit(input int i);
    logic [23:0] p;
    p = tab[i / 24];
    return p[23 - (i % 24)];
  endfunction

  // Starts a frame on the selected DUT and feeds tab[] until frame_done plus 40 cycles.
  // stall_len: cycles pixel_valid stays low while the sender waits for pixel 2.
  // coincide_rel: if nonzero, start is also sampled at edge e0+coincide_rel.
  task automatic run_frame(input int nleds, input int stall_len, input int coincide_rel,
                           output int e0, output int nxfer);
    int idx, stall, post, budget;
    rise_q.delete();
    fall_q.delete();
    done_n = 0; uf_n = 0; done_edge = 0;
    idx = 0; stall = 0; post = 0;
    budget = nleds * 3000 + 6000 + stall_len + 500;
    @(posedge clk); #1;
    pixel_data  = tab[0];
    pixel_valid = 1'b1;
    start       = 1'b1;
    e0          = edge_n + 1;
    for (int c = 0; c < budget && post < 40; c++) begin
      @(negedge clk);
      if (o_ready && pixel_valid) idx++;
      else if (o_ready && !pixel_valid) stall++;
      if (done_n > 0) post++;
      @(posedge clk); #1;
      start = (edge_n == e0 + 999) || (coincide_rel > 0 && edge_n == e0 + coincide_rel - 1);
      pixel_valid = !(idx == 2 && stall < stall_len);
      pixel_data  = tab[idx % 8];
    end
    start = 1'b0;
    nxfer = idx;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; sel = 1'b0;
    pixel_valid = 1'b0; pixel_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (d1_dout !== 1'b0) begin errors++; $display("FAIL reset d1_dout got %b want 0", d1_dout); end
    checks++; if (d1_busy !== 1'b0) begin errors++; $display("FAIL reset d1_busy got %b want 0", d1_busy); end
    checks++; if (if1.pixel_ready !== 1'b0) begin errors++; $display("FAIL reset d1_ready got %b want 0", if1.pixel_ready); end
    checks++; if (d1_done !== 1'b0) begin errors++; $display("FAIL reset d1_done got %b want 0", d1_done); end
    checks++; if (d1_uf !== 1'b0) begin errors++; $display("FAIL reset d1_underflow got %b want 0", d1_uf); end
    checks++; if (d8_dout !== 1'b0) begin errors++; $display("FAIL reset d8_dout got %b want 0", d8_dout); end
    checks++; if (d8_busy !== 1'b0) begin errors++; $display("FAIL reset d8_busy got %b want 0", d8_busy); end
    checks++; if (if8.pixel_ready !== 1'b0) begin errors++; $display("FAIL reset d8_ready got %b want 0", if8.pixel_ready); end
    checks++; if (d8_done !== 1'b0) begin errors++; $display("FAIL reset d8_done got %b want 0", d8_done); end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (d1_busy !== 1'b0) begin errors++; $display("FAIL start_during_reset busy got %b want 0", d1_busy); end
    checks++; if (if1.pixel_ready !== 1'b0) begin errors++; $display("FAIL start_during_reset ready got %b want 0", if1.pixel_ready); end
  endtask

  task automatic test_single_pixel();
    int e0, nx, nb, act, exp_v;
    logic b;
    sel = 1'b0;
    tab[0] = 24'h800001;
    run_frame(1, 0, 0, e0, nx);
    nb = 24;
    checks++; if (done_n !== 1) begin errors++; $display("FAIL single done_count got %0d want 1", done_n); end
    checks++; if (done_edge - e0 !== 9001) begin errors++; $display("FAIL single done_time got %0d want 9001", done_edge - e0); end
    checks++; if (nx !== 1) begin errors++; $display("FAIL single transfers got %0d want 1", nx); end
    checks++; if (uf_n !== 0) begin errors++; $display("FAIL single underflow got %0d want 0", uf_n); end
    checks++;
    if (rise_q.size() != nb || fall_q.size() != nb) begin
      errors++; $display("FAIL single edges got %0d/%0d want %0d", rise_q.size(), fall_q.size(), nb);
    end else begin
      checks++; if (rise_q[0] - e0 !== 1) begin errors++; $display("FAIL single first_rise got %0d want 1", rise_q[0] - e0); end
      for (int i = 0; i < nb; i++) begin
        b = exp_bit(i);
        exp_v = b ? 80 : 40;
        act = fall_q[i] - rise_q[i];
        checks++; if (act !== exp_v) begin errors++; $display("FAIL single hi bit %0d got %0d want %0d", i, act, exp_v); end
        exp_v = b ? 45 : 85;
        if (i == nb - 1) begin exp_v += 6000; act = done_edge - fall_q[i]; end
        else act = rise_q[i+1] - fall_q[i];
        checks++; if (act !== exp_v) begin errors++; $display("FAIL single lo bit %0d got %0d want %0d", i, act, exp_v); end
      end
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single busy_after got %b want 0", o_busy); end
  endtask

  task automatic test_reset_mid_bit();
    int c;
    bit seen;
    sel = 1'b1;
    pixel_data = 24'hFF0000; pixel_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (c >= 3000 && o_dout === 1'b1) begin
        seen = 1'b1;
        reset = 1'b1;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL reset_mid wait_high got timeout want dout=1"); end
    @(negedge clk);
    checks++; if (o_dout !== 1'b0) begin errors++; $display("FAIL reset_mid dout got %b want 0", o_dout); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", o_busy); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_mid ready got %b want 0", o_ready); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_mid idle_busy got %b want 0", o_busy); end
  endtask

  // Runs right after the mid-bit reset: a full frame from pixel 0 proves the restart.
  task automatic test_full_frame();
    int e0, nx, nb, act, exp_v;
    logic b;
    sel = 1'b1;
    tab[0] = 24'hFF0000; tab[1] = 24'h00FF00; tab[2] = 24'h0000FF; tab[3] = 24'h800001;
    tab[4] = 24'h123456; tab[5] = 24'hA5A5A5; tab[6] = 24'h5A5A5A; tab[7] = 24'h0000FF;
    run_frame(8, 0, 0, e0, nx);
    nb = 192;
    checks++; if (done_n !== 1) begin errors++; $display("FAIL full done_count got %0d want 1", done_n); end
    checks++; if (done_edge - e0 !== 30001) begin errors++; $display("FAIL full done_time got %0d want 30001", done_edge - e0); end
    checks++; if (nx !== 8) begin errors++; $display("FAIL full transfers got %0d want 8", nx); end
    checks++; if (uf_n !== 0) begin errors++; $display("FAIL full underflow got %0d want 0", uf_n); end
    checks++;
    if (rise_q.size() != nb || fall_q.size() != nb) begin
      errors++; $display("FAIL full edges got %0d/%0d want %0d", rise_q.size(), fall_q.size(), nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        b = exp_bit(i);
        exp_v = b ? 80 : 40;
        act = fall_q[i] - rise_q[i];
        checks++; if (act !== exp_v) begin errors++; $display("FAIL full hi bit %0d got %0d want %0d", i, act, exp_v); end
        exp_v = b ? 45 : 85;
        if (i == nb - 1) begin exp_v += 6000; act = done_edge - fall_q[i]; end
        else act = rise_q[i+1] - fall_q[i];
        checks++; if (act !== exp_v) begin errors++; $display("FAIL full lo bit %0d got %0d want %0d", i, act, exp_v); end
      end
    end
  endtask

  // 300-cycle stall before pixel 2, a start mid-frame, and a start sampled
  // on the edge that raises frame_done: none of the starts may begin a frame.
  task automatic test_underflow_start_ignore();
    int e0, nx, nb, act, exp_v;
    logic b;
    sel = 1'b1;
    run_frame(8, 300, 30301, e0, nx);
    nb = 192;
    checks++; if (uf_n !== 1) begin errors++; $display("FAIL underflow pulses got %0d want 1", uf_n); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL underflow done_count got %0d want 1", done_n); end
    checks++; if (done_edge - e0 !== 30301) begin errors++; $display("FAIL underflow done_time got %0d want 30301", done_edge - e0); end
    checks++; if (nx !== 8) begin errors++; $display("FAIL underflow transfers got %0d want 8", nx); end
    checks++;
    if (rise_q.size() != nb || fall_q.size() != nb) begin
      errors++; $display("FAIL underflow edges got %0d/%0d want %0d", rise_q.size(), fall_q.size(), nb);
    end else begin
      for (int i = 0; i < nb; i++) begin
        b = exp_bit(i);
        exp_v = b ? 80 : 40;
        act = fall_q[i] - rise_q[i];
        checks++; if (act !== exp_v) begin errors++; $display("FAIL underflow hi bit %0d got %0d want %0d", i, act, exp_v); end
        exp_v = (b ? 45 : 85) + ((i == 47) ? 300 : 0);
        if (i == nb - 1) begin exp_v += 6000; act = done_edge - fall_q[i]; end
        else act = rise_q[i+1] - fall_q[i];
        checks++; if (act !== exp_v) begin errors++; $display("FAIL underflow lo bit %0d got %0d want %0d", i, act, exp_v); end
      end
    end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL start_ignore busy_after got %b want 0", o_busy); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL start_ignore ready_after got %b want 0", o_ready); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0;
    pixel_valid = 1'b0; pixel_data = '0;
    for (int i = 0; i < 8; i++) tab[i] = '0;
    test_reset();
    test_single_pixel();
    test_reset_mid_bit();
    test_full_frame();
    test_underflow_start_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
